// File: rtl/event_ind_pkg.sv
// Shared types, constants and helpers for the multi-channel event-hold indicator.
// Latency: n/a (package only).
// Backpressure: n/a.
package event_ind_pkg;

    // Per-channel trigger qualification, encoded as on ch_mode_i.
    typedef enum logic [1:0] {
        EV_RISE   = 2'b00,
        EV_FALL   = 2'b01,
        EV_LVL_HI = 2'b10,
        EV_LVL_LO = 2'b11
    } ev_mode_t;

    // Cycles after reset release during which edge triggers are masked, so the
    // synchroniser filling up from its reset value is never seen as an edge.
    localparam int WARMUP_CYC = 3;

    // Clock cycles per millisecond, never less than one.
    function automatic int ms_div(input int clk_freq_hz);
        return (clk_freq_hz / 1000 > 0) ? (clk_freq_hz / 1000) : 1;
    endfunction

endpackage

// File: rtl/event_ind_ch.sv
// One event channel: 2-flop synchroniser, mode qualification, ms hold timer, optional event counter.
// Latency: event_i sampled at edge N -> hold counter loaded at edge N+2.
// Backpressure: none; free-running, every qualified event is accepted.
//
// Ports:
//   clk27, reset    clock and synchronous active-high reset
//   event_i         asynchronous event source
//   enable_i        channel enable; low forces the hold counter to 0
//   mode_i          trigger qualification (rise / fall / level-high / level-low)
//   hold_ms_i       hold time loaded on each trigger (0 = ignore trigger)
//   ms_tick         one-cycle millisecond strobe from the top level
//   warm_done       high once the post-reset warm-up has elapsed
//   cnt_clr_i       clear the event counter
//   active_o        hold counter non-zero
//   cnt_o           event counter value (0 unless EVENT_IND_CNT_EN is defined)
module event_ind_ch
    import event_ind_pkg::*;
#(
    parameter int MS_W  = 16,
    parameter int CNT_W = 8
) (
    input  logic             clk27,
    input  logic             reset,
    input  logic             event_i,
    input  logic             enable_i,
    input  ev_mode_t         mode_i,
    input  logic [MS_W-1:0]  hold_ms_i,
    input  logic             ms_tick,
    input  logic             warm_done,
    input  logic             cnt_clr_i,
    output logic             active_o,
    output logic [CNT_W-1:0] cnt_o
);

    logic            sync1;
    logic            sync2;
    logic            prev;
    logic            rise_edge;
    logic            fall_edge;
    logic            trig;
    logic            onset;
    logic [MS_W-1:0] hold_cnt;

    always_ff @(posedge clk27) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= event_i;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // Edges are masked during warm-up; levels are not, they carry no history.
    assign rise_edge = sync2 & ~prev & warm_done;
    assign fall_edge = ~sync2 & prev & warm_done;

    always_comb begin
        trig  = 1'b0;
        onset = 1'b0;
        case (mode_i)
            EV_RISE:   begin trig = rise_edge; onset = rise_edge; end
            EV_FALL:   begin trig = fall_edge; onset = fall_edge; end
            EV_LVL_HI: begin trig = sync2;     onset = rise_edge; end
            EV_LVL_LO: begin trig = ~sync2;    onset = fall_edge; end
            default:   begin trig = 1'b0;      onset = 1'b0;      end
        endcase
    end

    // A reload beats a coincident ms_tick so the full hold time is always served.
    always_ff @(posedge clk27) begin
        if (reset) begin
            hold_cnt <= '0;
        end else if (!enable_i) begin
            hold_cnt <= '0;
        end else if (trig && (hold_ms_i != '0)) begin
            hold_cnt <= hold_ms_i;
        end else if (ms_tick && (hold_cnt != '0)) begin
            hold_cnt <= hold_cnt - 1'b1;
        end
    end

    assign active_o = (hold_cnt != '0);

`ifdef EVENT_IND_CNT_EN
    logic [CNT_W-1:0] ev_cnt;

    // Saturating count of trigger onsets; clear has priority over increment.
    always_ff @(posedge clk27) begin
        if (reset) begin
            ev_cnt <= '0;
        end else if (cnt_clr_i) begin
            ev_cnt <= '0;
        end else if (enable_i && onset && (ev_cnt != '1)) begin
            ev_cnt <= ev_cnt + 1'b1;
        end
    end

    assign cnt_o = ev_cnt;
`else
    logic unused_cnt_in;
    assign unused_cnt_in = cnt_clr_i ^ onset;
    assign cnt_o         = '0;
`endif

endmodule

// File: rtl/event_indicator.sv
// Multi-channel event-hold indicator: per-channel ms hold timers OR-ed onto one indicator plus blink.
// Latency: event_i sampled at edge N -> active_o/indicator_o high after edge N+2.
// Backpressure: none; inputs are sampled every cycle.
//
// Optional feature: define EVENT_IND_CNT_EN to build per-channel saturating event counters
// readable through cnt_sel_i/cnt_o; otherwise cnt_o is 0 and cnt_sel_i/cnt_clr_i have no effect.
//
// Ports:
//   clk27, reset    single clock, synchronous active-high reset
//   event_i         NUM_CH asynchronous event sources
//   ch_enable_i     per-channel enable
//   ch_mode_i       per-channel mode, channel k at [2k+1:2k]
//   hold_ms_i       hold time in ms shared by all channels
//   active_o        per-channel hold active
//   indicator_o     OR of active_o
//   blink_o         indicator_o gated by the blink phase
//   cnt_sel_i       event counter select
//   cnt_clr_i       clear all event counters
//   cnt_o           selected event counter
module event_indicator
    import event_ind_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int CLK_FREQ_HZ = 27000000,
    parameter  int MS_W        = 16,
    parameter  int BLINK_MS    = 250,
    parameter  int CNT_W       = 8,
    localparam int SEL_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk27,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   event_i,
    input  logic [NUM_CH-1:0]   ch_enable_i,
    input  logic [2*NUM_CH-1:0] ch_mode_i,
    input  logic [MS_W-1:0]     hold_ms_i,
    output logic [NUM_CH-1:0]   active_o,
    output logic                indicator_o,
    output logic                blink_o,
    input  logic [SEL_W-1:0]    cnt_sel_i,
    input  logic                cnt_clr_i,
    output logic [CNT_W-1:0]    cnt_o
);

    localparam int DIV    = ms_div(CLK_FREQ_HZ);
    localparam int PRE_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int WARM_W = $clog2(WARMUP_CYC + 1);
    localparam int BL_W   = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    logic [PRE_W-1:0]  pre_cnt;
    logic              ms_tick;
    logic [WARM_W-1:0] warm_cnt;
    logic              warm_done;
    logic [BL_W-1:0]   blink_cnt;
    logic              blink_phase;
    logic [CNT_W-1:0]  ch_cnt [NUM_CH];

    // Millisecond prescaler, free-running from reset.
    assign ms_tick = (pre_cnt == PRE_W'(DIV - 1));

    always_ff @(posedge clk27) begin
        if (reset) begin
            pre_cnt <= '0;
        end else if (ms_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Warm-up counter stops once it reaches WARMUP_CYC.
    assign warm_done = (warm_cnt == WARM_W'(WARMUP_CYC));

    always_ff @(posedge clk27) begin
        if (reset) begin
            warm_cnt <= '0;
        end else if (!warm_done) begin
            warm_cnt <= warm_cnt + 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        event_ind_ch #(
            .MS_W  (MS_W),
            .CNT_W (CNT_W)
        ) u_ch (
            .clk27     (clk27),
            .reset     (reset),
            .event_i   (event_i[k]),
            .enable_i  (ch_enable_i[k]),
            .mode_i    (ev_mode_t'(ch_mode_i[2*k +: 2])),
            .hold_ms_i (hold_ms_i),
            .ms_tick   (ms_tick),
            .warm_done (warm_done),
            .cnt_clr_i (cnt_clr_i),
            .active_o  (active_o[k]),
            .cnt_o     (ch_cnt[k])
        );
    end

    assign indicator_o = |active_o;

    // Phase rests at 1 while idle so a new indication starts with the LED on.
    always_ff @(posedge clk27) begin
        if (reset) begin
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
        end else if (!indicator_o) begin
            blink_phase <= 1'b1;
            blink_cnt   <= '0;
        end else if (ms_tick) begin
            if (blink_cnt == BL_W'(BLINK_MS - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign blink_o = indicator_o & blink_phase;

    always_comb begin
        cnt_o = '0;
        if (int'(cnt_sel_i) < NUM_CH) begin
            cnt_o = ch_cnt[cnt_sel_i];
        end
    end

endmodule

// File: tb/tb_event_indicator.sv
// Self-checking bench for event_indicator with a deadline-based reference model.
// Latency: n/a.
// Backpressure: n/a.
module tb_event_indicator;

    localparam int NUM_CH = 4;
    localparam int DIV    = 27;
    localparam int BLINK  = 2;
    localparam int CMAX   = 255;

    logic        clk27 = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  ev    = '0;
    logic [3:0]  en    = '0;
    logic [7:0]  mode  = '0;
    logic [15:0] hold  = '0;
    logic [1:0]  sel   = '0;
    logic        clr   = 1'b0;
    logic [3:0]  active_o;
    logic        indicator_o;
    logic        blink_o;
    logic [7:0]  cnt_o;

    event_indicator #(
        .NUM_CH      (NUM_CH),
        .CLK_FREQ_HZ (27000),
        .MS_W        (16),
        .BLINK_MS    (BLINK),
        .CNT_W       (8)
    ) dut (
        .clk27       (clk27),
        .reset       (reset),
        .event_i     (ev),
        .ch_enable_i (en),
        .ch_mode_i   (mode),
        .hold_ms_i   (hold),
        .active_o    (active_o),
        .indicator_o (indicator_o),
        .blink_o     (blink_o),
        .cnt_sel_i   (sel),
        .cnt_clr_i   (clr),
        .cnt_o       (cnt_o)
    );

    always #5 clk27 = ~clk27;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model. Edges are numbered from reset release (edge 0 is the
    // first edge with reset low). ms ticks fall on edges k with k%DIV==DIV-1.
    // A trigger at edge k keeps the channel active up to (not including) the
    // hold-th tick strictly after k; that edge index is the channel deadline.
    int         k_edge = 0;
    logic [3:0] h1 = '0, h2 = '0, h3 = '0;   // event samples at edges k-1, k-2, k-3
    int         dl [NUM_CH];
    int         cm [NUM_CH];
    int         nt = 0;                       // ms ticks seen while indicator high
    bit         ind_m = 1'b0;
    logic [3:0] act_m = '0;

    function automatic int next_tick(input int kk);
        int r;
        r = (kk + 1) % DIV;
        return kk + 1 + ((DIV - 1 - r + DIV) % DIV);
    endfunction

    task automatic model_edge();
        bit tick;
        int m;
        bit s2, pv, t, on;
        if (reset) begin
            k_edge = 0; h1 = '0; h2 = '0; h3 = '0;
            for (int c = 0; c < NUM_CH; c++) begin dl[c] = 0; cm[c] = 0; end
            nt = 0; ind_m = 1'b0; act_m = '0;
            return;
        end
        tick = (k_edge % DIV) == DIV - 1;
        for (int c = 0; c < NUM_CH; c++) begin
            m  = (int'(mode) >> (2*c)) & 3;
            s2 = h2[c];
            pv = h3[c];
            case (m)
                0: begin t = s2 & ~pv & (k_edge >= 3); on = t; end
                1: begin t = ~s2 & pv & (k_edge >= 3); on = t; end
                2: begin t = s2;  on = s2 & ~pv & (k_edge >= 3); end
                default: begin t = ~s2; on = ~s2 & pv & (k_edge >= 3); end
            endcase
            if (!en[c]) dl[c] = 0;
            else if (t && hold != 0) dl[c] = next_tick(k_edge) + DIV * (int'(hold) - 1);
            if (clr) cm[c] = 0;
            else if (en[c] && on && cm[c] < CMAX) cm[c]++;
            act_m[c] = (k_edge < dl[c]);
        end
        if (ind_m) begin
            if (tick) nt++;
        end else begin
            nt = 0;
        end
        ind_m = |act_m;
        h3 = h2; h2 = h1; h1 = ev;
        k_edge++;
    endtask

    task automatic step();
        int exp_cnt;
        bit exp_blk;
        @(posedge clk27);
        model_edge();
        #1;
        exp_blk = ind_m && (((nt / BLINK) % 2) == 0);
`ifdef EVENT_IND_CNT_EN
        exp_cnt = cm[sel];
`else
        exp_cnt = 0;
`endif
        chk("active", int'(active_o), int'(act_m));
        chk("indicator", int'(indicator_o), int'(ind_m));
        chk("blink", int'(blink_o), int'(exp_blk));
        chk("cnt", int'(cnt_o), exp_cnt);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int len;
        // 1. reset with all inputs high, rise mode: warm-up must hide the fill-up edge
        ev = 4'hF; en = 4'hF; mode = 8'h00; hold = 16'd3;
        idle(5);
        chk("reset_active", int'(active_o), 0);
        chk("reset_blink", int'(blink_o), 0);
        reset = 1'b0;
        idle(200);
        chk("warmup_quiet", int'(active_o), 0);
        ev = 4'h0;
        idle(100);

        // 2. single pulse on ch0, hold 3 ms
        hold = 16'd3;
        ev[0] = 1'b1; step(); ev[0] = 1'b0;
        len = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (active_o[0]) len++;
        end
        chk("t2_len_in_55_81", int'(len >= 55 && len <= 81), 1);

        // 3. ch1 pulse, retrigger 40 cycles later with hold 5
        ev[1] = 1'b1; step(); ev[1] = 1'b0;
        idle(39);
        hold = 16'd5;
        ev[1] = 1'b1; step(); ev[1] = 1'b0;
        idle(170);

        // 4. ch2 level-high for 100 cycles, hold 1, then disable mid-hold
        mode = 8'b00_10_00_00; hold = 16'd1;
        ev[2] = 1'b1; idle(100); ev[2] = 1'b0;
        idle(2);
        en[2] = 1'b0; step();
        chk("t4_disable", int'(active_o[2]), 0);
        en[2] = 1'b1;
        idle(40);

        // 5. blink: ch0 level-high for 10 ms
        mode = 8'b00_00_00_10;
        ev[0] = 1'b1; idle(270); ev[0] = 1'b0;
        idle(60);
        chk("t5_blink_off", int'(blink_o), 0);
        mode = 8'h00;

        // 6. 300 pulses on ch3, then clear during a pulse
        sel = 2'd3;
        for (int i = 0; i < 300; i++) begin
            ev[3] = 1'b1; step(); ev[3] = 1'b0; step();
        end
        idle(4);
`ifdef EVENT_IND_CNT_EN
        chk("t6_saturated", int'(cnt_o), CMAX);
`else
        chk("t6_no_counter", int'(cnt_o), 0);
`endif
        ev[3] = 1'b1; clr = 1'b1; step(); ev[3] = 1'b0; step();
        clr = 1'b1; step(); clr = 1'b0;   // lands on the onset edge of that pulse
        idle(4);
        chk("t6_cleared", int'(cnt_o), 0);

        // 7. randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 49) == 0) mode = 8'($urandom);
            if ($urandom_range(0, 79) == 0) en   = 4'($urandom | 4'h3);
            if ($urandom_range(0, 59) == 0) hold = 16'($urandom_range(0, 4));
            for (int c = 0; c < NUM_CH; c++)
                if ($urandom_range(0, 7) == 0) ev[c] = ~ev[c];
            sel = 2'($urandom);
            clr = ($urandom_range(0, 99) == 0);
            step();
        end
        clr = 1'b0;

        // 8. reset mid-activity, then re-release
        reset = 1'b1; idle(3);
        chk("rst2_active", int'(active_o), 0);
        reset = 1'b0; idle(150);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
